// File: rtl/wb_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_rr
// Purpose  : Two-master round-robin arbiter in front of one Wishbone B4
//            pipelined slave; the grant is held for the whole bus cycle.
// Options  : WB_ARB_TIMEOUT_EN enables the ack watchdog and the m*_err pulse.
// Revision : 1.0 - initial release
// ============================================================================
module wb_arbiter_rr #(
    parameter int ADR_WIDTH = 16,
    parameter int DAT_WIDTH = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 m0_cyc,
    input  logic                 m0_stb,
    input  logic                 m0_we,
    input  logic [ADR_WIDTH-1:0] m0_adr,
    input  logic [DAT_WIDTH-1:0] m0_dat_m,
    output logic [DAT_WIDTH-1:0] m0_dat_s,
    output logic                 m0_ack,
    output logic                 m0_stall,
    output logic                 m0_err,

    input  logic                 m1_cyc,
    input  logic                 m1_stb,
    input  logic                 m1_we,
    input  logic [ADR_WIDTH-1:0] m1_adr,
    input  logic [DAT_WIDTH-1:0] m1_dat_m,
    output logic [DAT_WIDTH-1:0] m1_dat_s,
    output logic                 m1_ack,
    output logic                 m1_stall,
    output logic                 m1_err,

    output logic                 s_cyc,
    output logic                 s_stb,
    output logic                 s_we,
    output logic [ADR_WIDTH-1:0] s_adr,
    output logic [DAT_WIDTH-1:0] s_dat_m,
    input  logic [DAT_WIDTH-1:0] s_dat_s,
    input  logic                 s_ack,
    input  logic                 s_stall
);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_M0   = 2'd1,
        GNT_M1   = 2'd2
    } grant_t;

    grant_t               r_grant;
    grant_t               w_grant_next;
    logic                 r_last;
    logic                 w_last_next;
    logic [3:0]           r_outstanding;
    logic [3:0]           w_outstanding_next;

    logic                 w_sel_m0;
    logic                 w_sel_m1;
    logic                 w_owned;
    logic                 w_own_cyc;
    logic                 w_own_stb;
    logic                 w_own_we;
    logic [ADR_WIDTH-1:0] w_own_adr;
    logic [DAT_WIDTH-1:0] w_own_dat;

    logic                 w_full;
    logic                 w_hold;
    logic                 w_timeout;
    logic                 w_accept;
    logic                 w_ack_fwd;
    logic                 w_ack_dec;
    logic                 w_own_stall;
    logic                 w_grant_change;

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("wb_arbiter_rr: TIMEOUT must be at least 1");
    end

    // Owner selection; reset forces the idle view even before the grant register clears.
    always_comb begin
        w_sel_m0  = !rst && (r_grant == GNT_M0);
        w_sel_m1  = !rst && (r_grant == GNT_M1);
        w_owned   = w_sel_m0 || w_sel_m1;
        w_own_cyc = 1'b0;
        w_own_stb = 1'b0;
        w_own_we  = 1'b0;
        w_own_adr = '0;
        w_own_dat = '0;
        if (w_sel_m0) begin
            w_own_cyc = m0_cyc;
            w_own_stb = m0_stb;
            w_own_we  = m0_we;
            w_own_adr = m0_adr;
            w_own_dat = m0_dat_m;
        end else if (w_sel_m1) begin
            w_own_cyc = m1_cyc;
            w_own_stb = m1_stb;
            w_own_we  = m1_we;
            w_own_adr = m1_adr;
            w_own_dat = m1_dat_m;
        end
    end

    assign w_full      = (r_outstanding == 4'd15);
    assign s_cyc       = w_owned & w_own_cyc & ~w_hold;
    assign s_stb       = s_cyc & w_own_stb & ~w_full;
    assign s_we        = w_own_we;
    assign s_adr       = w_own_adr;
    assign s_dat_m     = w_own_dat;

    // Acks are only honoured while the owner's cycle is live on the slave.
    assign w_accept    = s_stb & ~s_stall;
    assign w_ack_fwd   = s_cyc & s_ack;
    assign w_ack_dec   = w_ack_fwd & (r_outstanding != 4'd0);
    assign w_own_stall = s_stall | w_full | w_hold;

    assign m0_dat_s    = s_dat_s;
    assign m0_ack      = w_sel_m0 & w_ack_fwd;
    assign m0_stall    = ~w_sel_m0 | w_own_stall;
    assign m0_err      = w_sel_m0 & w_timeout;

    assign m1_dat_s    = s_dat_s;
    assign m1_ack      = w_sel_m1 & w_ack_fwd;
    assign m1_stall    = ~w_sel_m1 | w_own_stall;
    assign m1_err      = w_sel_m1 & w_timeout;

    always_comb begin
        w_grant_next = r_grant;
        w_last_next  = r_last;
        case (r_grant)
            GNT_NONE: begin
                if (m0_cyc && m1_cyc) begin
                    w_grant_next = r_last ? GNT_M0 : GNT_M1;
                end else if (m0_cyc) begin
                    w_grant_next = GNT_M0;
                end else if (m1_cyc) begin
                    w_grant_next = GNT_M1;
                end
            end
            GNT_M0: begin
                if (!m0_cyc) begin
                    w_last_next  = 1'b0;
                    w_grant_next = m1_cyc ? GNT_M1 : GNT_NONE;
                end
            end
            GNT_M1: begin
                if (!m1_cyc) begin
                    w_last_next  = 1'b1;
                    w_grant_next = m0_cyc ? GNT_M0 : GNT_NONE;
                end
            end
            default: begin
                w_grant_next = GNT_NONE;
            end
        endcase
    end

    assign w_grant_change = (w_grant_next != r_grant);

    always_comb begin
        w_outstanding_next = r_outstanding;
        if (w_grant_change || w_timeout) begin
            w_outstanding_next = 4'd0;
        end else if (w_accept && !w_ack_dec) begin
            w_outstanding_next = r_outstanding + 4'd1;
        end else if (!w_accept && w_ack_dec) begin
            w_outstanding_next = r_outstanding - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant       <= GNT_NONE;
            r_last        <= 1'b1;
            r_outstanding <= 4'd0;
        end else begin
            r_grant       <= w_grant_next;
            r_last        <= w_last_next;
            r_outstanding <= w_outstanding_next;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int                  c_wdog_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_wdog_w-1:0] c_wdog_last = c_wdog_w'(TIMEOUT - 1);

    logic [c_wdog_w-1:0] r_wdog;
    logic                r_hold;

    // The timeout fires on the cycle the count would reach TIMEOUT; a same-cycle ack wins.
    assign w_timeout = s_cyc & ~s_ack & (r_outstanding != 4'd0) & (r_wdog == c_wdog_last);
    assign w_hold    = r_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog <= '0;
            r_hold <= 1'b0;
        end else if (w_grant_change) begin
            r_wdog <= '0;
            r_hold <= 1'b0;
        end else begin
            if (s_ack || w_timeout) begin
                r_wdog <= '0;
            end else if (r_outstanding != 4'd0) begin
                r_wdog <= r_wdog + 1'b1;
            end
            if (w_timeout) begin
                r_hold <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign w_hold    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/wb_arbiter_rr.md
# wb_arbiter_rr

Two-master round-robin arbiter that shares one Wishbone B4 pipelined slave port (cyc/stb/we/adr/dat/ack/stall) between two requesters. It holds the grant for the whole bus cycle (cyc high), tracks outstanding pipelined transfers, and routes ack/data only to the owner. It sits between CPU-side and DMA-side masters and a pipelined slave, or in front of the standard-to-pipelined slave wrapper.

## Interface
- adr_width, 16, address width
- dat_width, 16, data width
- timeout, 64, watchdog limit in cycles; used only with WB_ARB_TIMEOUT_EN
- clk  in  1  bus clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- m0_cyc, m0_stb, m0_we  in  1 each  master 0 cycle, strobe, write enable
- m0_adr  in  adr_width  master 0 address
- m0_dat_m  in  dat_width  master 0 write data
- m0_dat_s  out  dat_width  read data to master 0
- m0_ack, m0_stall, m0_err  out  1 each  master 0 ack, stall, error
- m1_*  same set as m0_*  master 1
- s_cyc, s_stb, s_we  out  1 each  to slave
- s_adr  out  adr_width; s_dat_m  out  dat_width  to slave
- s_dat_s  in  dat_width; s_ack, s_stall  in  1 each  from slave

## Operation
- State: grant ∈ {NONE, M0, M1}; last (last owner, 1 bit); outstanding (4-bit); wdog (only with macro).
- NONE: if exactly one m*_cyc high → grant it next edge. If both high → grant the master ≠ last. None high → stay.
- M0/M1: s_cyc, s_stb, s_we, s_adr, s_dat_m come combinationally from the owner. Owner sees m_ack = s_ack and m_stall = s_stall | (outstanding==15).
- Non-owner: m_stall=1, m_ack=0, m_err=0.
- m*_dat_s = s_dat_s for both masters. Only the owner's ack qualifies it.
- Release: in a cycle where the owner's cyc=0, s_cyc=0 and s_stb=0. At that edge last←owner. Grant moves directly to the other master if its cyc=1, else to NONE. The same master cannot regain the bus while the other is waiting.
- outstanding: +1 on s_stb & !s_stall; −1 on s_ack. A simultaneous +1/−1 leaves it unchanged. At 15, further strobes are stalled. Cleared to 0 on every grant change.
- Owner dropping cyc with outstanding>0 is a master protocol violation. The arbiter still releases and clears outstanding. Late slave acks are not forwarded.
- Reset (any cycle, including mid-transfer): grant=NONE, last=1 (master 0 wins first tie), outstanding=0, wdog=0.
- Output values in reset and in NONE: s_cyc=0, s_stb=0, m*_ack=0, m*_err=0, m*_stall=1. s_we, s_adr, s_dat_m = 0 in NONE.

## Timing
- Arbitration latency: 1 cycle. A request in cycle n gets its first forwarded strobe in cycle n+1.
- Handover between masters: 0 idle cycles beyond the owner's cyc-low cycle.
- Request, ack and stall paths: combinational, 0 added latency.
- Slave ack latency is passed through unchanged. Pipelined back-to-back strobes sustain 1 transfer/cycle while s_stall=0.

## Configuration
- WB_ARB_TIMEOUT_EN defined:
  - wdog counts cycles with outstanding>0 and s_ack=0; it clears on s_ack or on grant change.
  - When wdog reaches timeout: owner m_err=1 for exactly one cycle, outstanding←0, and s_cyc/s_stb are forced low until the owner drops cyc. Release then proceeds as normal.
  - s_ack arriving in the same cycle as the timeout takes priority: it is forwarded and no error is raised.
- Not defined: m*_err tied 0, no wdog register, and the timeout parameter is ignored.

## Test plan
- Single master: m0 writes adr 1..10 with data 101..110, then reads them back → each read returns 101..110; m1_ack stays 0 throughout.
- Simultaneous m0_cyc/m1_cyc asserted one cycle after reset → m0 granted first. After m0 drops cyc, m1 is granted at the next edge with no idle cycle. Repeat contention → m1 then m0 alternately.
- Pipelined burst: m1 issues 8 strobes with the slave returning ack 2 cycles later → 8 acks to m1, outstanding returns to 0, and there are 0 stall cycles when s_stall=0.
- Slave holds s_stall=1 for 5 cycles mid-burst → owner stall is high for those 5 cycles, and address/data are held and accepted once on release.
- rst asserted while m0 holds the grant with outstanding=3 → next cycle grant=NONE, s_cyc=0, both masters stall=1. With both masters requesting after reset, m0 wins.
- With WB_ARB_TIMEOUT_EN and timeout=16, slave never acks → m0_err pulses exactly once, 16 cycles after the strobe is accepted. s_cyc stays low until m0 drops cyc, after which a pending m1 is granted.
